// File: rtl/regfile_multiport.sv
// regfile_multiport
// Parametrised multi-port register file for the RISC-V datapath.
// Reads are registered with one cycle of latency. A write committed on the
// same edge as a read is forwarded to that read (write-first). Optionally,
// register 0 is hardwired to zero.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-high; clears storage, read_data, read_valid
//   write_en   : [NUM_WRITE] per-port write enable
//   write_addr : [NUM_WRITE*ADDR_WIDTH] packed write addresses, port k at k*ADDR_WIDTH
//   write_data : [NUM_WRITE*DATA_WIDTH] packed write data, port k at k*DATA_WIDTH
//   read_en    : [NUM_READ] per-port read request
//   read_addr  : [NUM_READ*ADDR_WIDTH] packed read addresses
//   read_data  : [NUM_READ*DATA_WIDTH] registered read data (holds when not read)
//   read_valid : [NUM_READ] high the cycle after a read request
module regfile_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WRITE-1:0]           write_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] write_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] write_data,
  input  logic [NUM_READ-1:0]            read_en,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ-1:0]            read_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]          regs [DEPTH];
  logic [DATA_WIDTH-1:0]          rd_byp_p0 [NUM_READ];
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data_p1;
  logic [NUM_READ-1:0]            rd_valid_p1;

  // True when the address is the hardwired zero register.
  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // ---- Stage p0: array lookup with write-first forwarding ----
  // Ports are scanned in ascending order so the highest-index enabled writer
  // to the read address wins, matching the commit priority below.
  always_comb begin
    for (int j = 0; j < NUM_READ; j++) begin
      rd_byp_p0[j] = regs[read_addr[j*ADDR_WIDTH +: ADDR_WIDTH]];
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (write_en[k] &&
            write_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == read_addr[j*ADDR_WIDTH +: ADDR_WIDTH])
          rd_byp_p0[j] = write_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (is_zero_reg(read_addr[j*ADDR_WIDTH +: ADDR_WIDTH]))
        rd_byp_p0[j] = '0;
    end
  end

  // ---- Stage p1: storage commit and registered read outputs ----
  // Later loop iterations override earlier ones, so on an address conflict
  // the highest-index write port is the one that lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      rd_data_p1  <= '0;
      rd_valid_p1 <= '0;
    end else begin
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (write_en[k] && !is_zero_reg(write_addr[k*ADDR_WIDTH +: ADDR_WIDTH]))
          regs[write_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] <= write_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
      rd_valid_p1 <= read_en;
      for (int j = 0; j < NUM_READ; j++) begin
        if (read_en[j])
          rd_data_p1[j*DATA_WIDTH +: DATA_WIDTH] <= rd_byp_p0[j];
      end
    end
  end

  assign read_data  = rd_data_p1;
  assign read_valid = rd_valid_p1;

endmodule

// File: tb/tb_regfile_multiport.sv
// Testbench for regfile_multiport. Two instances share the same stimulus:
// one with a hardwired zero register and one without (3 read, 2 write ports).
// A reference model (array updated write-first, then read) predicts outputs.
module tb_regfile_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int NW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [NW-1:0]  we;
  logic [NW*AW-1:0] wa;
  logic [NW*DW-1:0] wd;
  logic [NR-1:0]  re;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rdata_z, rdata_n;
  logic [NR-1:0]  rvalid_z, rvalid_n;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [DW-1:0] mz [32];
  logic [DW-1:0] mn [32];
  logic [DW-1:0] exp_z [NR];
  logic [DW-1:0] exp_n [NR];
  logic          exp_v [NR];

  always #5 clk = ~clk;

  regfile_multiport #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW), .ZERO_REG(1)
  ) dut_z (
    .clk(clk), .reset(reset), .write_en(we), .write_addr(wa), .write_data(wd),
    .read_en(re), .read_addr(ra), .read_data(rdata_z), .read_valid(rvalid_z)
  );

  regfile_multiport #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW), .ZERO_REG(0)
  ) dut_n (
    .clk(clk), .reset(reset), .write_en(we), .write_addr(wa), .write_data(wd),
    .read_en(re), .read_addr(ra), .read_data(rdata_n), .read_valid(rvalid_n)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rz(input int j);
    return rdata_z[j*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rn(input int j);
    return rdata_n[j*DW +: DW];
  endfunction

  task automatic idle();
    we = '0; wa = '0; wd = '0; re = '0; ra = '0; reset = 1'b0;
  endtask

  task automatic set_w(input int k, input int addr, input logic [DW-1:0] data);
    we[k] = 1'b1;
    wa[k*AW +: AW] = addr[AW-1:0];
    wd[k*DW +: DW] = data;
  endtask

  task automatic set_r(input int j, input int addr);
    re[j] = 1'b1;
    ra[j*AW +: AW] = addr[AW-1:0];
  endtask

  // Model: a reset clears everything; otherwise writes are applied in port
  // order (later port overwrites earlier), then reads see the updated array.
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mz[i] = '0;
        mn[i] = '0;
      end
      for (int j = 0; j < NR; j++) begin
        exp_z[j] = '0;
        exp_n[j] = '0;
        exp_v[j] = 1'b0;
      end
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (we[k]) begin
          int a;
          a = int'(wa[k*AW +: AW]);
          if (a != 0) mz[a] = wd[k*DW +: DW];
          mn[a] = wd[k*DW +: DW];
        end
      end
      for (int j = 0; j < NR; j++) begin
        exp_v[j] = re[j];
        if (re[j]) begin
          exp_z[j] = mz[int'(ra[j*AW +: AW])];
          exp_n[j] = mn[int'(ra[j*AW +: AW])];
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int j = 0; j < NR; j++) begin
      chk($sformatf("rdata_z%0d", j), rz(j), exp_z[j]);
      chk($sformatf("rdata_n%0d", j), rn(j), exp_n[j]);
      chk($sformatf("rvalid_z%0d", j), {31'd0, rvalid_z[j]}, {31'd0, exp_v[j]});
      chk($sformatf("rvalid_n%0d", j), {31'd0, rvalid_n[j]}, {31'd0, exp_v[j]});
    end
  endtask

  // One clock: inputs already driven; update model at the edge, sample after.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    idle();

    // reset state
    reset = 1'b1;
    cycle();
    cycle();
    chk("reset_valid", {29'd0, rvalid_z}, 32'd0);
    chk("reset_data0", rz(0), 32'd0);

    // reset clears a written register; read in reset cycle is ignored
    idle(); set_w(0, 5, 32'hDEADBEEF);
    cycle();
    idle(); reset = 1'b1; set_r(0, 5);
    cycle();
    chk("during_reset_valid", {31'd0, rvalid_n[0]}, 32'd0);
    idle();
    cycle();
    chk("after_reset_valid", {31'd0, rvalid_n[0]}, 32'd0);
    chk("after_reset_data", rn(0), 32'd0);
    idle(); set_r(0, 5);
    cycle();
    chk("r5_cleared", rn(0), 32'd0);
    chk("r5_cleared_valid", {31'd0, rvalid_n[0]}, 32'd1);

    // basic latency
    idle(); set_w(0, 3, 32'h12345678);
    cycle();
    idle(); set_r(0, 3);
    cycle();
    chk("latency_data", rz(0), 32'h12345678);
    chk("latency_valid", {31'd0, rvalid_z[0]}, 32'd1);
    idle();
    cycle();
    chk("latency_valid_drop", {31'd0, rvalid_z[0]}, 32'd0);

    // bypass
    idle(); set_w(0, 7, 32'h1111);
    cycle();
    idle(); set_w(0, 7, 32'h2222); set_r(0, 7); set_r(1, 7);
    cycle();
    chk("bypass_p0", rz(0), 32'h2222);
    chk("bypass_p1", rz(1), 32'h2222);
    idle(); set_r(2, 7);
    cycle();
    chk("bypass_stored", rn(2), 32'h2222);

    // zero register
    idle(); set_w(0, 0, 32'hFFFFFFFF); set_r(0, 0); set_r(1, 0); set_r(2, 0);
    cycle();
    chk("zero_byp_z", rz(1), 32'h0);
    chk("zero_byp_n", rn(1), 32'hFFFFFFFF);
    idle(); set_r(0, 0);
    cycle();
    chk("zero_later_z", rz(0), 32'h0);
    chk("zero_later_n", rn(0), 32'hFFFFFFFF);

    // write conflict
    idle(); set_w(0, 9, 32'hAAAA); set_w(1, 9, 32'hBBBB); set_r(0, 9);
    cycle();
    chk("conflict_byp", rz(0), 32'hBBBB);
    idle(); set_r(1, 9);
    cycle();
    chk("conflict_stored", rz(1), 32'hBBBB);

    // hold and independence
    idle(); set_w(0, 1, 32'h101); set_w(1, 2, 32'h202);
    cycle();
    idle(); set_r(0, 1); set_r(1, 2); set_r(2, 1);
    cycle();
    chk("indep_p0", rz(0), 32'h101);
    chk("indep_p1", rz(1), 32'h202);
    chk("indep_p2", rz(2), 32'h101);
    idle(); set_w(1, 1, 32'h111); set_r(0, 1); set_r(2, 1);
    cycle();
    chk("hold_p0", rz(0), 32'h111);
    chk("hold_p1", rz(1), 32'h202);
    chk("hold_p1_valid", {31'd0, rvalid_z[1]}, 32'd0);
    chk("hold_p2", rz(2), 32'h111);

    // random sweep; narrow address range half the time to force conflicts
    for (int c = 0; c < 500; c++) begin
      idle();
      reset = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < NW; k++) begin
        if ($urandom_range(0, 2) != 0)
          set_w(k, $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31), $urandom());
      end
      for (int j = 0; j < NR; j++) begin
        if ($urandom_range(0, 3) != 0)
          set_r(j, $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31));
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised register file for the simple RISC-V datapath, succeeding the fixed 32x32, 2-read/1-write register file. It supports configurable data width, depth, read-port count and write-port count, with registered reads, same-cycle write-to-read bypass and an optional hardwired zero register. A synchronous reset clears all storage. It sits between the decode stage (read addresses) and the writeback stage (write ports).

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH
NUM_READ, 2, number of read ports (1..8)
NUM_WRITE, 1, number of write ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is an ordinary register

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
write_en  input  NUM_WRITE  per-port write enable
write_addr  input  NUM_WRITE*ADDR_WIDTH  write addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
write_data  input  NUM_WRITE*DATA_WIDTH  write data; port k at [k*DATA_WIDTH +: DATA_WIDTH]
read_en  input  NUM_READ  per-port read request
read_addr  input  NUM_READ*ADDR_WIDTH  read addresses, packed as for write_addr
read_data  output  NUM_READ*DATA_WIDTH  registered read data, packed as for write_data
read_valid  output  NUM_READ  high for the cycle read_data[j] holds the result of a read issued the previous cycle

Behaviour:
- Reset (sampled on clk edge while reset=1): every register, read_data and read_valid go to 0. Writes and reads presented in a reset cycle are ignored. Reset takes effect mid-operation regardless of pending reads; the cycle after reset deasserts starts from an all-zero state.
- Write: on an edge with write_en[k]=1, register[write_addr[k]] <= write_data[k].
- Write conflict: when two or more enabled ports target the same address, the highest-index port wins. Lower ports to that address are dropped.
- ZERO_REG=1: writes to address 0 are discarded. Reads of address 0 return 0, including via bypass. ZERO_REG=0: address 0 behaves like every other address.
- Read latency: 1 cycle. For read_en[j]=1 at edge N, read_data[j] after edge N equals the register value including writes committed at edge N (write-first bypass). read_valid[j] is 1 after edge N.
- Bypass: if any enabled write port targets read_addr[j] at the same edge, read_data[j] takes that write's data, using the same highest-index-wins priority. Bypass is suppressed for address 0 when ZERO_REG=1.
- read_en[j]=0: read_data[j] holds its previous value and read_valid[j] goes to 0.
- Read ports are fully independent. Any number of ports may read the same address in the same cycle.
- Storage is plain registers, with no initial blocks relied upon. Reset is the only initialisation.
- Out-of-range address cannot occur, since depth = 2**ADDR_WIDTH.

Test Plan:
- Reset/clear: write 0xDEADBEEF to r5, assert reset for 1 cycle, then read r5 -> read_data=0x00000000 and read_valid=1 one cycle after the read; read_valid=0 and read_data=0 during and immediately after reset.
- Basic latency: write 0x12345678 to r3 at edge N; read r3 on port 0 at edge N+1 -> read_data[0]=0x12345678 after edge N+1; read_valid[0] high for exactly 1 cycle.
- Bypass: with r7=0x1111, in the same cycle write r7<=0x2222 and read r7 on both ports -> both read_data=0x2222 the next cycle; reading r7 again later also gives 0x2222.
- Zero register (ZERO_REG=1): write r0<=0xFFFFFFFF with a simultaneous read of r0 -> read_data=0 that cycle and on all later reads. Repeat with ZERO_REG=0 -> 0xFFFFFFFF via bypass and on later reads.
- Write conflict (NUM_WRITE=2): port0 writes r9<=0xAAAA and port1 writes r9<=0xBBBB in the same cycle, with a simultaneous read of r9 -> bypassed and stored value both 0xBBBB.
- Hold and independence (NUM_READ=3): read r1, r2 and r1 on ports 0-2, then drop read_en[1] -> ports 0 and 2 track r1; port 1 holds its last value with read_valid[1]=0. Finish with a random write/read sweep against a reference-model scoreboard.
